// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet sprite block.
// Also holds the elaboration-time parameter consistency check.
package bullet_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } bullet_state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // The RAM address must be exactly {row offset, column offset} of a power-of-2 sprite.
  function automatic logic bullet_cfg_ok(input int addr_w, input int size,
                                         input int h_max, input int v_max);
    logic pow2;
    pow2 = (size >= 32'sd2) && ((size & (size - 32'sd1)) == 32'sd0);
    return pow2 && (addr_w == 32'sd2 * $clog2(size)) &&
           (size <= h_max) && (size <= v_max);
  endfunction

endpackage

// File: rtl/bullet_cfg_chk.sv
// Elaboration-only guard: refuses to build with an inconsistent SIZE/ADDR pair.
module bullet_cfg_chk
  import bullet_pkg::*;
#(
  parameter int ADDR  = 6,
  parameter int SIZE  = 8,
  parameter int H_MAX = 640,
  parameter int V_MAX = 480
) ();

  if (!bullet_cfg_ok(ADDR, SIZE, H_MAX, V_MAX)) begin : g_cfg_bad
    $error("bullet_sprite_core: ADDR must equal 2*clog2(SIZE), SIZE a power of 2");
  end

endmodule

// File: rtl/bullet_ram.sv
// Bullet bitmap store: one write port, one read port with registered read data.
// A same-cycle read and write to one address returns the old contents.
module bullet_ram #(
  parameter int CD   = 12,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [CD-1:0]   wr_data,
  input  logic [ADDR-1:0] rd_addr,
  output logic [CD-1:0]   rd_data
);

  logic [CD-1:0] mem_r [0:(2**ADDR)-1];

  // Host bitmap write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read.
  always_ff @(posedge clk) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/bullet_sprite_core.sv
// Bullet sprite: per-frame motion FSM, pixel hit test, and a 2-cycle
// RAM-read / chroma-key compositing pipeline over the incoming video.
module bullet_sprite_core
  import bullet_pkg::*;
#(
  parameter int             CD        = 12,
  parameter int             ADDR      = 6,
  parameter int             SIZE      = 8,
  parameter int             H_MAX     = 640,
  parameter int             V_MAX     = 480,
  parameter int             STEP      = 4,
  parameter logic [CD-1:0]  KEY_COLOR = 12'h000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  input  logic            frame_tick,
  input  logic            fire,
  input  logic [10:0]     fire_x,
  input  logic [10:0]     fire_y,
  input  logic            fire_dir,
  input  logic            wr_en,
  input  logic [ADDR-1:0] wr_addr,
  input  logic [CD-1:0]   wr_data,
  input  logic [CD-1:0]   si_rgb,
  output logic [CD-1:0]   so_rgb,
  output logic            busy
);

  localparam int          SW        = $clog2(SIZE);
  localparam logic [11:0] SIZE_12   = 12'(SIZE);
  localparam logic [11:0] STEP_12   = 12'(STEP);
  localparam logic [10:0] STEP_11   = 11'(STEP);
  localparam logic [11:0] RIGHT_LIM = 12'(H_MAX - SIZE);

  bullet_state_t state_r, state_s;
  logic [10:0]   bx_r, bx_s, by_r, by_s;
  logic          dir_r, dir_s;

  logic [11:0]   bx_ext_s, by_ext_s, x_ext_s, y_ext_s;
  logic          hit_s, hit_d1_r;
  logic [SW-1:0] dx_s, dy_s;
  logic [ADDR-1:0] rd_addr_s;
  logic [CD-1:0] dout_s, si_rgb_d1_r, so_rgb_r;

  bullet_cfg_chk #(.ADDR(ADDR), .SIZE(SIZE), .H_MAX(H_MAX), .V_MAX(V_MAX)) u_cfg_chk ();

  assign bx_ext_s = {1'b0, bx_r};
  assign by_ext_s = {1'b0, by_r};
  assign x_ext_s  = {1'b0, x};
  assign y_ext_s  = {1'b0, y};

  // Flight state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      bx_r    <= 11'd0;
      by_r    <= 11'd0;
      dir_r   <= DIR_RIGHT;
    end else begin
      state_r <= state_s;
      bx_r    <= bx_s;
      by_r    <= by_s;
      dir_r   <= dir_s;
    end
  end

  // Launch and per-frame motion; the bullet retires rather than wrapping at either edge.
  always_comb begin
    state_s = state_r;
    bx_s    = bx_r;
    by_s    = by_r;
    dir_s   = dir_r;
    case (state_r)
      IDLE: begin
        if (fire) begin
          state_s = FLYING;
          bx_s    = fire_x;
          by_s    = fire_y;
          dir_s   = fire_dir;
        end else begin
          state_s = IDLE;
        end
      end
      FLYING: begin
        if (!frame_tick) begin
          state_s = FLYING;
        end else if (dir_r == DIR_RIGHT) begin
          if ((bx_ext_s + STEP_12) > RIGHT_LIM) begin
            state_s = IDLE;
          end else begin
            bx_s = bx_r + STEP_11;
          end
        end else begin
          if (bx_ext_s < STEP_12) begin
            state_s = IDLE;
          end else begin
            bx_s = bx_r - STEP_11;
          end
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Low bits of the offset only need the low bits of each operand.
  assign dx_s      = x[SW-1:0] - bx_r[SW-1:0];
  assign dy_s      = y[SW-1:0] - by_r[SW-1:0];
  assign rd_addr_s = {dy_s, dx_s};
  assign hit_s     = (state_r == FLYING) &&
                     (x_ext_s >= bx_ext_s) && (x_ext_s < (bx_ext_s + SIZE_12)) &&
                     (y_ext_s >= by_ext_s) && (y_ext_s < (by_ext_s + SIZE_12));

  bullet_ram #(.CD(CD), .ADDR(ADDR)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (dout_s)
  );

  // Align hit/background with the RAM read, then composite with chroma key.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d1_r    <= 1'b0;
      si_rgb_d1_r <= '0;
      so_rgb_r    <= '0;
    end else begin
      hit_d1_r    <= hit_s;
      si_rgb_d1_r <= si_rgb;
      so_rgb_r    <= (hit_d1_r && (dout_s != KEY_COLOR)) ? dout_s : si_rgb_d1_r;
    end
  end

  assign so_rgb = so_rgb_r;
  assign busy   = (state_r == FLYING);

endmodule
